// File: rtl/cpx_det_pkg.sv
// Shared widths, sum-width helper and detector state encoding for the
// complex energy detector.
package cpx_det_pkg;

  localparam int SAMP_W = 13;
  localparam int MAG_W  = 26;

  function automatic int sum_w(input int log2_win);
    return MAG_W + log2_win;
  endfunction

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_ABOVE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } det_state_t;

endpackage

// File: rtl/cpx_mag2.sv
// Stage 1: registered squared magnitude of a complex sample, tagged with
// its sample index and a one-cycle valid.
module cpx_mag2
  import cpx_det_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_rdy,
  input  logic signed [SAMP_W-1:0] re,
  input  logic signed [SAMP_W-1:0] im,
  output logic [MAG_W-1:0]         mag2,
  output logic                     mag2_valid,
  output logic [CNT_W-1:0]         mag2_idx
);

  logic [CNT_W-1:0]        idx;
  logic signed [MAG_W-1:0] re_x, im_x, re_sq, im_sq;

  // Sign-extend first so the squares are formed at full product width.
  assign re_x  = MAG_W'(re);
  assign im_x  = MAG_W'(im);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  always_ff @(posedge clk) begin
    if (reset) begin
      mag2       <= '0;
      mag2_valid <= 1'b0;
      mag2_idx   <= '0;
      idx        <= '0;
    end else begin
      mag2_valid <= data_rdy;
      if (data_rdy) begin
        mag2     <= $unsigned(re_sq) + $unsigned(im_sq);
        mag2_idx <= idx;
        idx      <= idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpx_energy_det.sv
// Sliding-window energy detector with hysteresis and holdoff; flags ping
// arrival and timestamps it with the triggering sample index.
module cpx_energy_det
  import cpx_det_pkg::*;
#(
  parameter int LOG2_WIN = 4,
  parameter int HOLDOFF  = 8,
  parameter int CNT_W    = 16,
  localparam int SUM_W   = sum_w(LOG2_WIN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_rdy,
  input  logic signed [SAMP_W-1:0] re,
  input  logic signed [SAMP_W-1:0] im,
  input  logic [SUM_W-1:0]         thr_hi,
  input  logic [SUM_W-1:0]         thr_lo,
  output logic [SUM_W-1:0]         pwr,
  output logic                     pwr_valid,
  output logic                     det,
  output logic [CNT_W-1:0]         det_time,
  output logic                     active
);

  localparam int WIN  = 1 << LOG2_WIN;
  localparam int HC_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [MAG_W-1:0]    mag2;
  logic                m_valid;
  logic [CNT_W-1:0]    m_idx;
  logic [MAG_W-1:0]    win_mem [WIN];
  logic [LOG2_WIN-1:0] wptr;
  logic [SUM_W-1:0]    sum, sum_next;
  logic [LOG2_WIN:0]   fill_cnt;
  logic                full_now;
  logic [HC_W-1:0]     hcnt;
  det_state_t          state;

  cpx_mag2 #(.CNT_W(CNT_W)) u_mag2 (
    .clk        (clk),
    .reset      (reset),
    .data_rdy   (data_rdy),
    .re         (re),
    .im         (im),
    .mag2       (mag2),
    .mag2_valid (m_valid),
    .mag2_idx   (m_idx)
  );

  assign sum_next = sum + SUM_W'(mag2) - SUM_W'(win_mem[wptr]);
  // True for the update that completes the window and every one after.
  assign full_now = (fill_cnt >= (LOG2_WIN + 1)'(WIN - 1));
  assign active   = (state == ST_ABOVE) || (state == ST_HOLDOFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwr       <= '0;
      pwr_valid <= 1'b0;
      det       <= 1'b0;
      det_time  <= '0;
      sum       <= '0;
      wptr      <= '0;
      fill_cnt  <= '0;
      hcnt      <= '0;
      state     <= ST_FILL;
      for (int unsigned i = 0; i < WIN; i++) win_mem[i] <= '0;
    end else begin
      pwr_valid <= 1'b0;
      det       <= 1'b0;
      if (m_valid) begin
        sum           <= sum_next;
        pwr           <= sum_next;
        win_mem[wptr] <= mag2;
        wptr          <= wptr + LOG2_WIN'(1);
        pwr_valid     <= full_now;
        if (!fill_cnt[LOG2_WIN]) fill_cnt <= fill_cnt + (LOG2_WIN + 1)'(1);
        // The sample that fills the window is judged as if already searching.
        case (state)
          ST_FILL, ST_SEARCH: begin
            if (state == ST_SEARCH || full_now) begin
              if (sum_next >= thr_hi) begin
                state    <= ST_ABOVE;
                det      <= 1'b1;
                det_time <= m_idx;
              end else begin
                state <= ST_SEARCH;
              end
            end
          end
          ST_ABOVE: begin
            if (sum_next <= thr_lo) begin
              state <= ST_HOLDOFF;
              hcnt  <= HC_W'(HOLDOFF);
            end
          end
          ST_HOLDOFF: begin
            if (hcnt <= HC_W'(1)) state <= ST_SEARCH;
            else                  hcnt  <= hcnt - HC_W'(1);
          end
          default: state <= ST_FILL;
        endcase
      end
    end
  end

endmodule
